// File: rtl/usart_pkg.sv
// Shared definitions for the USART transmit and receive paths:
// frame state encoding, parity modes and the parity helper.
package usart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } usart_state_e;

   localparam int PARITY_NONE = 0;
   localparam int PARITY_EVEN = 1;
   localparam int PARITY_ODD  = 2;

   // Wide enough to index up to 8 data bits or 2 stop bits.
   localparam int BIT_CNT_W = 3;

   function automatic logic parity_bit(input logic [7:0] data, input int data_bits, input int mode);
      logic p;
      p = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (i < data_bits) p = p ^ data[i];
      end
      if (mode == PARITY_EVEN) return p;
      if (mode == PARITY_ODD)  return ~p;
      return 1'b0;
   endfunction

endpackage

// File: rtl/usart_bit_timer.sv
// Serial bit-period timer: down-counts CLOCKS_PER_BIT-1..0 and pulses tick
// on the last cycle of each bit; restart holds it at the top of a bit.
module usart_bit_timer #(
   parameter int CLOCKS_PER_BIT = 16
) (
   input  logic comm_clock,
   input  logic reset,
   input  logic restart,
   output logic tick
);

   localparam int CNT_W = (CLOCKS_PER_BIT > 1) ? $clog2(CLOCKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLOCKS_PER_BIT - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q - 1'b1;
      if (restart || (cnt_q == '0)) cnt_d = RELOAD;
   end

   always_ff @(posedge comm_clock) begin
      if (reset) cnt_q <= RELOAD;
      else       cnt_q <= cnt_d;
   end

   assign tick = (cnt_q == '0);

endmodule

// File: rtl/usart_tx.sv
// USART transmitter: pops bytes from the FIFO read side and serialises
// start / data (LSB first) / optional parity / stop bits on tx.
//
// state     | meaning
// ST_IDLE   | line high, ready for a byte
// ST_START  | start bit (0)
// ST_DATA   | DATA_BITS data bits, LSB first
// ST_PARITY | parity bit (only when PARITY != none)
// ST_STOP   | STOP_BITS stop bits (1); last cycle may accept the next byte
module usart_tx #(
   parameter int CLOCKS_PER_BIT = 16,
   parameter int DATA_BITS      = 8,
   parameter int PARITY         = 0,
   parameter int STOP_BITS      = 1
) (
   input  logic       comm_clock,
   input  logic       reset,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] in_data,
   output logic       tx,
   output logic       busy
);

   import usart_pkg::*;

   localparam logic [BIT_CNT_W-1:0] LAST_DATA = BIT_CNT_W'(DATA_BITS - 1);
   localparam logic [BIT_CNT_W-1:0] LAST_STOP = BIT_CNT_W'(STOP_BITS - 1);

   usart_state_e         state_q, state_d;
   logic [7:0]           shift_q, shift_d;
   logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
   logic                 par_q, par_d;
   logic                 tx_q, tx_d;
   logic                 tick;
   logic                 timer_restart;
   logic                 frame_end;
   logic                 xfer;

   assign timer_restart = (state_q == ST_IDLE);

   usart_bit_timer #(
      .CLOCKS_PER_BIT(CLOCKS_PER_BIT)
   ) u_bit_timer (
      .comm_clock(comm_clock),
      .reset     (reset),
      .restart   (timer_restart),
      .tick      (tick)
   );

   // Accepting in the final stop cycle gives gap-free back-to-back frames.
   assign frame_end = (state_q == ST_STOP) && tick && (bit_cnt_q == LAST_STOP);
   assign in_ready  = !reset && ((state_q == ST_IDLE) || frame_end);
   assign xfer      = in_valid && in_ready;

   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
      par_d     = par_q;
      tx_d      = 1'b1;

      unique case (state_q)
         ST_IDLE: begin
            if (xfer) state_d = ST_START;
         end
         ST_START: begin
            if (tick) begin
               state_d   = ST_DATA;
               bit_cnt_d = '0;
            end
         end
         ST_DATA: begin
            if (tick) begin
               if (bit_cnt_q == LAST_DATA) begin
                  state_d   = (PARITY == PARITY_NONE) ? ST_STOP : ST_PARITY;
                  bit_cnt_d = '0;
               end else begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
                  shift_d   = {1'b0, shift_q[7:1]};
               end
            end
         end
         ST_PARITY: begin
            if (tick) begin
               state_d   = ST_STOP;
               bit_cnt_d = '0;
            end
         end
         ST_STOP: begin
            if (tick) begin
               if (bit_cnt_q == LAST_STOP) state_d = xfer ? ST_START : ST_IDLE;
               else                        bit_cnt_d = bit_cnt_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (xfer) begin
         shift_d = in_data;
         par_d   = parity_bit(in_data, DATA_BITS, PARITY);
      end

      // tx follows the state being entered so it is a clean register output.
      unique case (state_d)
         ST_START:  tx_d = 1'b0;
         ST_DATA:   tx_d = shift_d[0];
         ST_PARITY: tx_d = par_d;
         default:   tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge comm_clock) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         shift_q   <= '0;
         bit_cnt_q <= '0;
         par_q     <= 1'b0;
         tx_q      <= 1'b1;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         bit_cnt_q <= bit_cnt_d;
         par_q     <= par_d;
         tx_q      <= tx_d;
      end
   end

   assign tx   = tx_q;
   assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_usart_tx.sv
// Bench for usart_tx: four differently configured instances, each checked
// every cycle against a frame-timeline model, plus directed literal frames.
module tb_usart_tx;

   logic       clk;
   logic [3:0] rst;
   logic [3:0] in_valid;
   logic [3:0] in_ready;
   logic [7:0] in_data [4];
   logic [3:0] tx;
   logic [3:0] busy;

   int n_checks = 0;
   int n_errors = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   usart_tx #(.CLOCKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
      .comm_clock(clk), .reset(rst[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .in_data(in_data[0]), .tx(tx[0]), .busy(busy[0]));
   usart_tx #(.CLOCKS_PER_BIT(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u1 (
      .comm_clock(clk), .reset(rst[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .in_data(in_data[1]), .tx(tx[1]), .busy(busy[1]));
   usart_tx #(.CLOCKS_PER_BIT(3), .DATA_BITS(5), .PARITY(2), .STOP_BITS(2)) u2 (
      .comm_clock(clk), .reset(rst[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
      .in_data(in_data[2]), .tx(tx[2]), .busy(busy[2]));
   usart_tx #(.CLOCKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u3 (
      .comm_clock(clk), .reset(rst[3]), .in_valid(in_valid[3]), .in_ready(in_ready[3]),
      .in_data(in_data[3]), .tx(tx[3]), .busy(busy[3]));

   function automatic int cpb_of(input int k);
      return (k == 2) ? 3 : 4;
   endfunction
   function automatic int db_of(input int k);
      return (k == 2) ? 5 : 8;
   endfunction
   function automatic int par_of(input int k);
      return (k == 1) ? 1 : ((k == 2) ? 2 : 0);
   endfunction
   function automatic int sb_of(input int k);
      return (k >= 2) ? 2 : 1;
   endfunction
   function automatic int len_of(input int k);
      return 1 + db_of(k) + ((par_of(k) != 0) ? 1 : 0) + sb_of(k);
   endfunction

   // Frame as a bit list: index 0 = start bit, then data, parity, stops.
   function automatic logic [15:0] build_frame(input int k, input logic [7:0] d);
      logic [15:0] f;
      int ones;
      int idx;
      f = '1;
      f[0] = 1'b0;
      ones = 0;
      for (int i = 0; i < db_of(k); i++) begin
         f[1 + i] = d[i];
         ones += int'(d[i]);
      end
      idx = 1 + db_of(k);
      if (par_of(k) == 1) f[idx] = ((ones % 2) == 1);
      else if (par_of(k) == 2) f[idx] = ((ones % 2) == 0);
      return f;
   endfunction

   task automatic check(input string name, input int k, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL u%0d %s: got %0h expected %0h at %0t", k, name, got, exp, $time);
      end
   endtask

   // Model: one frame occupies len*cpb cycles starting the cycle after the
   // accepting edge; the last cycle of a frame may accept the next byte.
   task automatic run_model(input int k);
      bit          active = 0;
      bit          live = 0;
      int          pos = 0;
      int          last;
      logic [15:0] frame = '1;
      bit          r, v, exp_rdy;
      logic [7:0]  d;
      last = len_of(k) * cpb_of(k) - 1;
      forever begin
         @(posedge clk);
         r = rst[k];
         v = in_valid[k];
         d = in_data[k];
         exp_rdy = !active || (pos == last);
         if (r) begin
            active = 0;
            pos = 0;
            live = 1;
         end else if (v && exp_rdy) begin
            frame = build_frame(k, d);
            active = 1;
            pos = 0;
         end else if (active && pos == last) begin
            active = 0;
         end else if (active) begin
            pos++;
         end
         @(negedge clk);
         if (live) begin
            check("tx", k, tx[k], active ? frame[pos / cpb_of(k)] : 1'b1);
            check("busy", k, busy[k], active);
            if (!rst[k]) check("in_ready", k, in_ready[k], !active || (pos == last));
         end
      end
   endtask

   task automatic send(input int k, input logic [7:0] b);
      bit ok;
      bit rdy;
      ok = 0;
      @(posedge clk);
      #1;
      in_valid[k] = 1'b1;
      in_data[k] = b;
      for (int n = 0; n < 200 && !ok; n++) begin
         @(negedge clk);
         rdy = in_ready[k];
         @(posedge clk);
         #1;
         if (rdy) ok = 1;
      end
      in_valid[k] = 1'b0;
      in_data[k] = 8'($urandom);
      check("handshake", k, ok, 1'b1);
   endtask

   // Starts right after the accepting edge; samples each bit mid-period.
   task automatic capture(input int k, output logic [15:0] bits, output int busy_n,
                          output int first_rdy, output int low_n);
      int c;
      c = cpb_of(k);
      bits = '0;
      busy_n = 0;
      low_n = 0;
      first_rdy = -1;
      for (int j = 0; j < len_of(k) * c; j++) begin
         @(negedge clk);
         if ((j % c) == (c / 2)) bits[j / c] = tx[k];
         if (busy[k]) busy_n++;
         if (tx[k] == 1'b0) low_n++;
         if (in_ready[k] && first_rdy < 0) first_rdy = j;
      end
   endtask

   task automatic directed(input int k, input logic [7:0] b, input logic [15:0] exp_bits,
                           input int exp_busy, input int exp_rdy, input int exp_low);
      logic [15:0] bits;
      int bn, fr, ln;
      send(k, b);
      capture(k, bits, bn, fr, ln);
      check("frame_bits", k, bits, exp_bits);
      check("busy_cycles", k, bn, exp_busy);
      check("ready_cycle", k, fr, exp_rdy);
      check("low_cycles", k, ln, exp_low);
   endtask

   task automatic reset_and_idle(input int k, input int idle_n);
      rst[k] = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst[k] = 1'b0;
      repeat (idle_n) @(posedge clk);
   endtask

   task automatic random_phase(input int k, input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         rst[k] = ($urandom_range(0, 299) == 0);
         in_valid[k] = ($urandom_range(0, 2) != 0);
         in_data[k] = 8'($urandom);
      end
      rst[k] = 1'b0;
      in_valid[k] = 1'b0;
      repeat (60) @(posedge clk);
   endtask

   task automatic drive0();
      logic [15:0] bits;
      int bn, fr, ln;
      reset_and_idle(0, 100);
      directed(0, 8'hAA, 16'h0354, 40, 39, 20);
      // Back-to-back: next byte waits on in_valid like a FIFO head.
      send(0, 8'hAA);
      in_valid[0] = 1'b1;
      in_data[0] = 8'hBB;
      capture(0, bits, bn, fr, ln);
      check("b2b_first_bits", 0, bits, 16'h0354);
      @(posedge clk);
      #1;
      in_valid[0] = 1'b0;
      in_data[0] = 8'h00;
      capture(0, bits, bn, fr, ln);
      check("b2b_second_bits", 0, bits, 16'h0376);
      check("b2b_second_busy", 0, bn, 40);
      check("b2b_second_ready", 0, fr, 39);
      // Reset during data bit 3 of 0xFF.
      send(0, 8'hFF);
      repeat (18) @(negedge clk);
      @(posedge clk);
      #1;
      rst[0] = 1'b1;
      @(posedge clk);
      #1;
      rst[0] = 1'b0;
      @(negedge clk);
      check("after_reset_tx", 0, tx[0], 1'b1);
      check("after_reset_busy", 0, busy[0], 1'b0);
      check("after_reset_ready", 0, in_ready[0], 1'b1);
      directed(0, 8'h55, 16'h02AA, 40, 39, 20);
      random_phase(0, 2000);
   endtask

   task automatic drive_other(input int k, input logic [7:0] b, input logic [15:0] exp_bits,
                              input int exp_busy, input int exp_rdy, input int exp_low);
      reset_and_idle(k, 5);
      directed(k, b, exp_bits, exp_busy, exp_rdy, exp_low);
      random_phase(k, 2000);
   endtask

   initial run_model(0);
   initial run_model(1);
   initial run_model(2);
   initial run_model(3);

   initial begin
      rst = 4'hF;
      in_valid = 4'h0;
      for (int i = 0; i < 4; i++) in_data[i] = 8'h00;
      fork
         drive0();
         drive_other(1, 8'h07, 16'h060E, 44, 43, 24);
         drive_other(2, 8'h07, 16'h018E, 27, 26, 12);
         drive_other(3, 8'h00, 16'h0600, 44, 43, 36);
      join
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: run did not complete, errors=%0d checks=%0d", n_errors, n_checks);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/usart_tx.md
Name: usart_tx

Overview:
- Serial transmitter for the USART path; consumes bytes from the read side of usart_fifo (out_valid/out_ready/out_data) and emits asynchronous frames on one TX line.
- Frame: start bit (0), DATA_BITS data bits LSB-first, optional parity bit, STOP_BITS stop bits (1).
- Single comm_clock domain; bit timing derived from a clock divider.

Parameters:
- CLOCKS_PER_BIT, 16, comm_clock cycles per serial bit; must be >= 2.
- DATA_BITS, 8, data bits per frame; range 5..8.
- PARITY, 0, 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1, stop bits per frame; 1 or 2.

Ports:
- comm_clock  input  1  clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  byte available; driven from usart_fifo out_valid.
- in_ready  output  1  transmitter accepts a byte this cycle; drives usart_fifo out_ready.
- in_data  input  8  byte to send; bits [DATA_BITS-1:0] are used, upper bits ignored.
- tx  output  1  serial line; idles high.
- busy  output  1  high while a frame is in progress.

Behaviour:
- Clocking and reset: already decided — one clock (comm_clock); reset is synchronous and active-high.
- Reset values: state IDLE, tx=1, busy=0, in_ready=1 from the first cycle after reset deasserts. While reset is high, no transfer is accepted.
- Transfer: occurs on a rising edge where in_valid && in_ready. in_data is latched into a shift register on that edge. No other in_data sampling.
- States and transitions:
  - IDLE -> START on transfer.
  - START -> DATA.
  - DATA -> PARITY, or -> STOP when PARITY=0.
  - PARITY -> STOP.
  - STOP -> IDLE, or -> START on transfer.
- Bit timing: each state holds tx for exactly CLOCKS_PER_BIT cycles. DATA holds for DATA_BITS bit periods, STOP for STOP_BITS bit periods.
- Counters: the bit timer counts CLOCKS_PER_BIT-1 down to 0 and reloads. The bit counter indexes data or stop bits. Counter width is $clog2(CLOCKS_PER_BIT).
- tx drive:
  - tx is registered. The first start-bit cycle is the cycle after the transfer edge.
  - tx=0 in START; tx=shift[0] in DATA, with a right shift at each bit boundary.
  - tx=parity in PARITY: even = XOR of data bits; odd = its inverse.
  - tx=1 in STOP and IDLE.
- in_ready: high in IDLE, and in the final cycle of the final stop bit. This gives zero-gap back-to-back frames. Low otherwise.
- busy: high from the cycle after the transfer through the last stop-bit cycle. It stays continuously high across back-to-back frames.
- Frame length: (1 + DATA_BITS + (PARITY != 0) + STOP_BITS) * CLOCKS_PER_BIT cycles.
- Boundary cases:
  - in_valid rising mid-frame is ignored until in_ready; the FIFO holds the byte.
  - in_data changing after the transfer has no effect.
  - Reset mid-frame: next cycle tx=1, busy=0, in_ready=1, partial frame abandoned, no byte consumed.
  - Reset coincident with a transfer: the transfer is discarded.

Decomposition:
- Package usart_pkg holds:
  - state encoding (IDLE, START, DATA, PARITY, STOP);
  - parity constants PARITY_NONE=0, PARITY_EVEN=1, PARITY_ODD=2.
- The package is shared with the future usart_rx.
- One sub-module: usart_bit_timer (CLOCKS_PER_BIT parameter, inputs comm_clock/reset/restart, output tick on the last cycle of a bit). Reused by usart_rx.

Test Plan (CLOCKS_PER_BIT=4, DATA_BITS=8, STOP_BITS=1 unless noted):
- Single byte 0xAA, PARITY=0, one-cycle in_valid -> tx sequence 0,0,1,0,1,0,1,0,1,1 with 4 cycles per bit (40 cycles); busy high for exactly 40 cycles; in_ready low from cycle 1 to 38, high at cycle 39.
- usart_fifo with 0xAA then 0xBB queued feeding usart_tx -> 80 contiguous frame cycles with no idle gap; second frame bits 0,1,1,0,1,1,1,0,1,1; FIFO out_empty asserts after the second pop.
- PARITY=1 with 0x07 -> parity bit 1, frame 44 cycles. PARITY=2 with 0x07 -> parity bit 0.
- STOP_BITS=2 with 0x00 -> tx low for 36 cycles, then high for 8; in_ready reasserts in cycle 43.
- Reset pulsed for 1 cycle during data bit 3 of 0xFF -> tx=1, busy=0, in_ready=1 on the next cycle; a following 0x55 transmits as 0,1,0,1,0,1,0,1,0,1.
- in_valid held low for 100 cycles after reset -> tx=1, in_ready=1, busy=0 throughout.
